// File: rtl/ex_ctrl_pipe.sv
// EX-stage control: decodes the ID instruction into operand/branch/RV32M controls,
// holds them for the instruction resident in EX and sequences multi-cycle mul/div.
module ex_ctrl_pipe #(
    parameter int MUL_CYCLES = 1,
    parameter int DIV_CYCLES = 32,
    parameter int CNT_W      = 7
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       id_valid,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    input  logic       ex_stall_in,
    input  logic       flush,
    output logic       id_stall,
    output logic       ex_valid,
    output logic       ex_done,
    output logic       a_sel,
    output logic       b_sel,
    output logic [2:0] branch_alu_op,
    output logic       md_en,
    output logic [2:0] md_op
);

    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [CNT_W-1:0] MUL_LAT_M1 = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LAT_M1 = CNT_W'(DIV_CYCLES - 1);

    typedef enum logic [1:0] {
        S_EMPTY,
        S_BUSY,
        S_READY
    } state_t;

    state_t           state_p1, state_nxt;
    logic [CNT_W-1:0] cnt_p1, cnt_nxt;

    logic             dec_a_sel_p0;
    logic             dec_b_sel_p0;
    logic [2:0]       dec_bop_p0;
    logic             dec_md_p0;
    logic [2:0]       dec_md_op_p0;
    logic [CNT_W-1:0] dec_lat_m1_p0;

    logic accept;
    logic retire;

    // Stage p0: decode of the instruction presented by ID
    always_comb begin
        dec_a_sel_p0  = (opcode == OP_AUIPC) || (opcode == OP_JAL) || (opcode == OP_BRANCH);
        dec_b_sel_p0  = (opcode != OP_REG);
        dec_bop_p0    = 3'b011;
        if ((opcode == OP_JAL) || (opcode == OP_JALR))
            dec_bop_p0 = 3'b010;
        else if (opcode == OP_BRANCH)
            dec_bop_p0 = funct3;
        dec_md_p0     = (opcode == OP_REG) && (funct7 == 7'b0000001);
        dec_md_op_p0  = dec_md_p0 ? funct3 : 3'b000;
        dec_lat_m1_p0 = '0;
        if (dec_md_p0)
            dec_lat_m1_p0 = funct3[2] ? DIV_LAT_M1 : MUL_LAT_M1;
    end

    assign ex_valid = (state_p1 != S_EMPTY);
    assign ex_done  = (state_p1 == S_READY);
    assign id_stall = ex_valid && (!ex_done || ex_stall_in);
    assign accept   = id_valid && !id_stall && !flush;
    assign retire   = ex_done && !ex_stall_in;

    // Flush outranks everything; the counter keeps running under a downstream stall.
    always_comb begin
        state_nxt = state_p1;
        cnt_nxt   = cnt_p1;
        if (flush) begin
            state_nxt = S_EMPTY;
            cnt_nxt   = '0;
        end else if (accept) begin
            cnt_nxt   = dec_lat_m1_p0;
            state_nxt = (dec_lat_m1_p0 == '0) ? S_READY : S_BUSY;
        end else begin
            case (state_p1)
                S_BUSY: begin
                    cnt_nxt = cnt_p1 - 1'b1;
                    if (cnt_p1 == CNT_W'(1))
                        state_nxt = S_READY;
                end
                S_READY: begin
                    if (retire)
                        state_nxt = S_EMPTY;
                end
                default: begin
                    state_nxt = S_EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_p1 <= S_EMPTY;
            cnt_p1   <= '0;
        end else begin
            state_p1 <= state_nxt;
            cnt_p1   <= cnt_nxt;
        end
    end

    // Stage p1: control fields held for the EX-resident instruction
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sel         <= 1'b0;
            b_sel         <= 1'b0;
            branch_alu_op <= 3'b011;
            md_en         <= 1'b0;
            md_op         <= 3'b000;
        end else if (accept) begin
            a_sel         <= dec_a_sel_p0;
            b_sel         <= dec_b_sel_p0;
            branch_alu_op <= dec_bop_p0;
            md_en         <= dec_md_p0;
            md_op         <= dec_md_op_p0;
        end
    end

endmodule
